alarm_bank: RTL and testbench

Parametrised successor to the single-pair alarm comparator. It holds NUM_ALARMS independently programmable HH:MM alarm slots, each with its own enable and its own state machine. Adds snooze with a bounded repeat count, auto-stop after a ring timeout, and a per-slot ring vector. It sits beside the BCD time-of-day counter, consumes that counter's digit outputs plus a 1 Hz tick, and drives the alarm indicator and display logic.

---
 rtl/alarm_pkg.sv | 23 ++
 rtl/alarm_slot.sv | 124 ++++++++++++
 rtl/alarm_bank.sv | 90 +++++++++
 tb/tb_alarm_bank.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm bank.
//   alarm_state_t : per-slot FSM state encoding
//   bcd_hhmm_t    : {h1,h0,m1,m0} BCD time word
//   cnt_width()   : counter width for a modulus, never below 1 bit
package alarm_pkg;

    localparam int unsigned MAX_SLOTS = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2,
        DONE    = 2'd3
    } alarm_state_t;

    typedef logic [15:0] bcd_hhmm_t;

    // Bits needed to hold 0..n-1, with a floor of one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alarm_slot.sv
// One alarm slot: time/enable registers, state machine, ring/snooze counters.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   sec_tick              1 Hz strobe; cur_time valid this cycle
//   cur_time              current {h1,h0,m1,m0}
//   alarm_en              global enable
//   stop_alarm, snooze    command pulses shared by all slots
//   cfg_wr                write strobe already decoded for this slot
//   cfg_time, cfg_slot_en values written on cfg_wr
//   ringing               slot is in RINGING
//   snoozed               slot is in SNOOZED
module alarm_slot
    import alarm_pkg::*;
#(
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      sec_tick,
    input  bcd_hhmm_t cur_time,
    input  logic      alarm_en,
    input  logic      stop_alarm,
    input  logic      snooze,
    input  logic      cfg_wr,
    input  bcd_hhmm_t cfg_time,
    input  logic      cfg_slot_en,
    output logic      ringing,
    output logic      snoozed
);

    localparam int unsigned RW = cnt_width(RING_SEC);
    localparam int unsigned WW = cnt_width(SNOOZE_SEC);
    localparam int unsigned SW = cnt_width(MAX_SNOOZE + 1);

    localparam logic [RW-1:0] RING_LOAD = RW'(RING_SEC - 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(SNOOZE_SEC - 1);
    localparam logic [SW-1:0] SNZ_MAX   = SW'(MAX_SNOOZE);

    alarm_state_t  r_state;
    bcd_hhmm_t     r_time;
    logic          r_en;
    logic [RW-1:0] r_ring_cnt;
    logic [WW-1:0] r_wait_cnt;
    logic [SW-1:0] r_snz_cnt;

    logic          w_match;

    // Seconds are not part of the compare; only HH:MM equality matters.
    assign w_match = (cur_time == r_time);

    // Slot FSM; branch order encodes cfg > !alarm_en > stop > snooze > tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_time     <= '0;
            r_en       <= 1'b0;
            r_ring_cnt <= '0;
            r_wait_cnt <= '0;
            r_snz_cnt  <= '0;
        end else if (cfg_wr) begin
            r_state    <= IDLE;
            r_time     <= cfg_time;
            r_en       <= cfg_slot_en;
            r_ring_cnt <= '0;
            r_wait_cnt <= '0;
            r_snz_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (sec_tick && w_match && r_en && alarm_en) begin
                        r_state    <= RINGING;
                        r_ring_cnt <= RING_LOAD;
                        r_snz_cnt  <= '0;
                    end
                end
                RINGING: begin
                    if (!alarm_en || stop_alarm) begin
                        r_state <= DONE;
                    end else if (snooze) begin
                        // Snooze budget spent: the press acts as stop.
                        if (r_snz_cnt < SNZ_MAX) begin
                            r_state    <= SNOOZED;
                            r_wait_cnt <= WAIT_LOAD;
                            r_snz_cnt  <= r_snz_cnt + SW'(1);
                        end else begin
                            r_state <= DONE;
                        end
                    end else if (sec_tick) begin
                        if (r_ring_cnt == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_ring_cnt <= r_ring_cnt - RW'(1);
                        end
                    end
                end
                SNOOZED: begin
                    if (!alarm_en || stop_alarm) begin
                        r_state <= DONE;
                    end else if (sec_tick) begin
                        if (r_wait_cnt == '0) begin
                            r_state    <= RINGING;
                            r_ring_cnt <= RING_LOAD;
                        end else begin
                            r_wait_cnt <= r_wait_cnt - WW'(1);
                        end
                    end
                end
                DONE: begin
                    // Hold until the alarm minute has passed to avoid retrigger.
                    if (sec_tick && !w_match) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ringing = (r_state == RINGING);
    assign snoozed = (r_state == SNOOZED);

endmodule

// File: rtl/alarm_bank.sv
// Bank of NUM_ALARMS independent HH:MM alarm slots with snooze and auto-stop.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   sec_tick                           1 Hz strobe from the time-of-day counter
//   hour1..sec0                        current BCD digits (seconds unused)
//   alarm_en, stop_alarm, snooze       global enable and command pulses
//   cfg_we, cfg_idx, cfg_time,
//   cfg_slot_en                        slot configuration write
//   ring_vec                           per-slot ringing flags
//   alarm_out                          any slot ringing
//   ring_idx                           lowest ringing slot, 0 when none
//   snoozed_any                        any slot snoozed
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned SNOOZE_SEC = 300,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned RING_SEC   = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sec_tick,
    input  logic [3:0]            hour1,
    input  logic [3:0]            hour0,
    input  logic [3:0]            min1,
    input  logic [3:0]            min0,
    input  logic [3:0]            sec1,
    input  logic [3:0]            sec0,
    input  logic                  alarm_en,
    input  logic                  stop_alarm,
    input  logic                  snooze,
    input  logic                  cfg_we,
    input  logic [cnt_width(NUM_ALARMS)-1:0] cfg_idx,
    input  logic [15:0]           cfg_time,
    input  logic                  cfg_slot_en,
    output logic [NUM_ALARMS-1:0] ring_vec,
    output logic                  alarm_out,
    output logic [cnt_width(NUM_ALARMS)-1:0] ring_idx,
    output logic                  snoozed_any
);

    localparam int unsigned IW = cnt_width(NUM_ALARMS);

    bcd_hhmm_t             w_cur_time;
    logic [NUM_ALARMS-1:0] w_cfg_wr;
    logic [NUM_ALARMS-1:0] w_snoozed;
    logic                  w_unused_sec;

    assign w_cur_time   = {hour1, hour0, min1, min0};
    assign w_unused_sec = ^{sec1, sec0};

    // Out-of-range cfg_idx matches no slot, so the write is dropped.
    for (genvar g = 0; g < int'(NUM_ALARMS); g++) begin : g_slot
        assign w_cfg_wr[g] = cfg_we && (cfg_idx == IW'(g));

        alarm_slot #(
            .SNOOZE_SEC (SNOOZE_SEC),
            .MAX_SNOOZE (MAX_SNOOZE),
            .RING_SEC   (RING_SEC)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .sec_tick    (sec_tick),
            .cur_time    (w_cur_time),
            .alarm_en    (alarm_en),
            .stop_alarm  (stop_alarm),
            .snooze      (snooze),
            .cfg_wr      (w_cfg_wr[g]),
            .cfg_time    (cfg_time),
            .cfg_slot_en (cfg_slot_en),
            .ringing     (ring_vec[g]),
            .snoozed     (w_snoozed[g])
        );
    end

    assign alarm_out   = |ring_vec;
    assign snoozed_any = |w_snoozed;

    // Lowest-index priority encoder: scan high to low so the lowest wins.
    always_comb begin
        ring_idx = '0;
        for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
            if (ring_vec[i]) begin
                ring_idx = IW'(i);
            end
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
module tb_alarm_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       sec_tick;
    logic [3:0] hour1, hour0, min1, min0, sec1, sec0;
    logic       alarm_en, stop_alarm, snooze;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [15:0] cfg_time;
    logic       cfg_slot_en;
    logic [3:0] ring_vec;
    logic       alarm_out;
    logic [1:0] ring_idx;
    logic       snoozed_any;

    int total = 0;
    int bad   = 0;
    int th, tm, ts;
    logic ok;

    alarm_bank #(
        .NUM_ALARMS (4),
        .SNOOZE_SEC (300),
        .MAX_SNOOZE (3),
        .RING_SEC   (60)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sec_tick    (sec_tick),
        .hour1       (hour1),
        .hour0       (hour0),
        .min1        (min1),
        .min0        (min0),
        .sec1        (sec1),
        .sec0        (sec0),
        .alarm_en    (alarm_en),
        .stop_alarm  (stop_alarm),
        .snooze      (snooze),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_time    (cfg_time),
        .cfg_slot_en (cfg_slot_en),
        .ring_vec    (ring_vec),
        .alarm_out   (alarm_out),
        .ring_idx    (ring_idx),
        .snoozed_any (snoozed_any)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_digits();
        hour1 = 4'(th / 10); hour0 = 4'(th % 10);
        min1  = 4'(tm / 10); min0  = 4'(tm % 10);
        sec1  = 4'(ts / 10); sec0  = 4'(ts % 10);
    endtask

    task automatic set_time(input int h, input int m, input int s);
        th = h; tm = m; ts = s;
        drive_digits();
    endtask

    // Advance bench clock by one second and strobe sec_tick for one cycle.
    task automatic tick();
        ts++;
        if (ts == 60) begin ts = 0; tm++; end
        if (tm == 60) begin tm = 0; th++; end
        if (th == 24) th = 0;
        drive_digits();
        sec_tick = 1'b1;
        @(posedge clk); #1;
        sec_tick = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [15:0] t, input logic en);
        cfg_we = 1'b1; cfg_idx = idx; cfg_time = t; cfg_slot_en = en;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse(input logic do_stop, input logic do_snz);
        stop_alarm = do_stop; snooze = do_snz;
        @(posedge clk); #1;
        stop_alarm = 1'b0; snooze = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sec_tick = 1'b0;
        alarm_en = 1'b1; stop_alarm = 1'b0; snooze = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_time = '0; cfg_slot_en = 1'b0;
        set_time(6, 59, 58);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_ring_vec", 32'(ring_vec), 32'h0);
        chk("reset_alarm_out", 32'(alarm_out), 32'h0);
        chk("reset_ring_idx", 32'(ring_idx), 32'h0);
        chk("reset_snoozed", 32'(snoozed_any), 32'h0);

        // Basic trigger at 07:00
        cfg_write(2'd0, 16'h0700, 1'b1);
        tick();  // 06:59:59
        chk("pre_match_quiet", 32'(ring_vec), 32'h0);
        tick();  // 07:00:00
        chk("trig_ring_vec", 32'(ring_vec), 32'h1);
        chk("trig_alarm_out", 32'(alarm_out), 32'h1);
        chk("trig_ring_idx", 32'(ring_idx), 32'h0);

        // Three snoozes of 300 s each
        for (int n = 0; n < 3; n++) begin
            pulse(1'b0, 1'b1);
            chk("snz_ring_off", 32'(ring_vec), 32'h0);
            ok = 1'b1;
            for (int k = 0; k < 299; k++) begin
                tick();
                if (snoozed_any !== 1'b1 || ring_vec !== 4'h0) ok = 1'b0;
            end
            chk("snz_hold_299", 32'(ok), 32'h1);
            tick();
            chk("snz_rering", 32'(ring_vec), 32'h1);
            chk("snz_cleared", 32'(snoozed_any), 32'h0);
        end
        // Budget exhausted: fourth press stops
        pulse(1'b0, 1'b1);
        chk("snz4_stop_ring", 32'(ring_vec), 32'h0);
        chk("snz4_stop_snz", 32'(snoozed_any), 32'h0);

        // Unattended ring auto-stops after 60 ticks
        set_time(6, 59, 58);
        tick();  // 06:59:59, DONE -> IDLE
        tick();  // 07:00:00
        chk("auto_trig", 32'(ring_vec), 32'h1);
        for (int k = 0; k < 59; k++) tick();
        chk("auto_59_still", 32'(ring_vec), 32'h1);
        tick();  // 07:01:00
        chk("auto_stop", 32'(ring_vec), 32'h0);
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (ring_vec !== 4'h0) ok = 1'b0;
        end
        chk("auto_stays_off", 32'(ok), 32'h1);

        // Two slots on the same minute; stop and snooze together
        cfg_write(2'd1, 16'h1230, 1'b1);
        cfg_write(2'd3, 16'h1230, 1'b1);
        set_time(12, 29, 59);
        tick();  // 12:30:00
        chk("dual_ring_vec", 32'(ring_vec), 32'ha);
        chk("dual_ring_idx", 32'(ring_idx), 32'h1);
        pulse(1'b1, 1'b1);
        chk("dual_stop_vec", 32'(ring_vec), 32'h0);
        chk("dual_stop_snz", 32'(snoozed_any), 32'h0);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (ring_vec !== 4'h0) ok = 1'b0;
        end
        chk("dual_no_retrig", 32'(ok), 32'h1);

        // Slot3 alone gives ring_idx 3
        cfg_write(2'd3, 16'h1232, 1'b1);
        set_time(12, 31, 59);
        tick();  // 12:32:00
        chk("s3_ring_vec", 32'(ring_vec), 32'h8);
        chk("s3_ring_idx", 32'(ring_idx), 32'h3);
        pulse(1'b1, 1'b0);

        // Reconfigure a ringing slot
        cfg_write(2'd2, 16'h1233, 1'b1);
        set_time(12, 32, 59);
        tick();  // 12:33:00
        chk("s2_ring_vec", 32'(ring_vec), 32'h4);
        chk("s2_ring_idx", 32'(ring_idx), 32'h2);
        cfg_write(2'd2, 16'h0815, 1'b1);
        chk("s2_cfg_drop", 32'(ring_vec), 32'h0);
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (ring_vec !== 4'h0) ok = 1'b0;
        end
        chk("s2_no_retrig", 32'(ok), 32'h1);
        // Writing the current minute arms on the next tick
        cfg_write(2'd2, 16'h1233, 1'b1);
        tick();  // 12:33:05
        chk("s2_cur_min_trig", 32'(ring_vec), 32'h4);

        // Global disable kills ringing and snoozed slots
        pulse(1'b0, 1'b1);
        chk("s2_snoozed", 32'(snoozed_any), 32'h1);
        alarm_en = 1'b0;
        @(posedge clk); #1;
        chk("dis_snz_off", 32'(snoozed_any), 32'h0);
        chk("dis_ring_off", 32'(ring_vec), 32'h0);
        cfg_write(2'd1, 16'h1234, 1'b1);
        set_time(12, 33, 59);
        tick();  // 12:34:00
        chk("dis_no_trig", 32'(ring_vec), 32'h0);

        // Re-enable at 23:59 and cross midnight; disabled slot1 stays quiet
        cfg_write(2'd0, 16'h0000, 1'b1);
        cfg_write(2'd1, 16'h0000, 1'b0);
        set_time(23, 59, 58);
        alarm_en = 1'b1;
        tick();  // 23:59:59
        chk("mid_pre", 32'(ring_vec), 32'h0);
        tick();  // 00:00:00
        chk("mid_ring_vec", 32'(ring_vec), 32'h1);
        chk("mid_alarm_out", 32'(alarm_out), 32'h1);

        // Reset while ringing clears everything
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst2_ring_vec", 32'(ring_vec), 32'h0);
        chk("rst2_alarm_out", 32'(alarm_out), 32'h0);
        set_time(23, 59, 59);
        tick();  // 00:00:00; slot time cleared to 0000 but enable cleared
        chk("rst2_cfg_cleared", 32'(ring_vec), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
